fp_issue_ctrl: RTL and testbench

- Front end for the FP add unit.
- Accepts a stream of FP instructions into a small in-order queue:
  - FADD: fd = fs + ft.
  - FLOAD: writes an immediate into register fd through the unit's memory write port.
- Issues one FADD at a time on the unit's start/stall/address interface and tracks completion through the unit's working signal.
- Schedules FLOADs only when the unit is idle, so a load write never coincides with an FPU result write-back.

---
 rtl/fp_issue_if.sv | 38 +++
 rtl/fp_issue_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fp_issue_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_issue_if.sv
// Bundle between the FP instruction source, the issue controller and the FP add unit.
// The controller takes the slave view; the instruction source / FPU side takes the master view.
interface fp_issue_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              in_op;
  logic [ADDR_W-1:0] in_fs;
  logic [ADDR_W-1:0] in_ft;
  logic [ADDR_W-1:0] in_fd;
  logic [DATA_W-1:0] in_imm;
  logic              working;
  logic              start;
  logic              stall;
  logic [ADDR_W-1:0] fs_addr;
  logic [ADDR_W-1:0] ft_addr;
  logic [ADDR_W-1:0] fd_addr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              m_write;
  logic              idle;
  logic              err;
  logic [7:0]        done_cnt;

  modport master (
    output in_valid, in_op, in_fs, in_ft, in_fd, in_imm, working,
    input  in_ready, start, stall, fs_addr, ft_addr, fd_addr,
           m_addr, m_data, m_write, idle, err, done_cnt
  );

  modport slave (
    input  in_valid, in_op, in_fs, in_ft, in_fd, in_imm, working,
    output in_ready, start, stall, fs_addr, ft_addr, fd_addr,
           m_addr, m_data, m_write, idle, err, done_cnt
  );
endinterface

// File: rtl/fp_issue_ctrl.sv
// In-order issue front end for the FP add unit: queues FADD/FLOAD instructions,
// issues one FADD at a time and performs FLOAD writes only while the unit is idle.
module fp_issue_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 3
) (
  input logic       clk,
  input logic       rst,
  fp_issue_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] fs;
    logic [ADDR_W-1:0] ft;
    logic [ADDR_W-1:0] fd;
    logic [DATA_W-1:0] imm;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  entry_t            mem [DEPTH];
  entry_t            in_entry;
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  state_t            state;
  logic [TMO_W-1:0]  tcnt;
  logic              start;
  logic              stall;
  logic [ADDR_W-1:0] fs_addr;
  logic [ADDR_W-1:0] ft_addr;
  logic [ADDR_W-1:0] fd_addr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              m_write;
  logic              err;
  logic [7:0]        done_cnt;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push     = bus.in_valid & ~full;
  // The head is only consumed from IDLE, so a queued FLOAD never overtakes a running FADD.
  assign pop      = (state == S_IDLE) & ~empty;
  assign head     = mem[rd_ptr];
  assign in_entry = '{op: bus.in_op, fs: bus.in_fs, ft: bus.in_ft,
                      fd: bus.in_fd, imm: bus.in_imm};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tcnt     <= '0;
      start    <= 1'b0;
      stall    <= 1'b1;
      fs_addr  <= '0;
      ft_addr  <= '0;
      fd_addr  <= '0;
      m_addr   <= '0;
      m_data   <= '0;
      m_write  <= 1'b0;
      err      <= 1'b0;
      done_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          m_write <= 1'b0;
          if (pop) begin
            if (head.op) begin
              m_write <= 1'b1;
              m_addr  <= head.fd;
              m_data  <= head.imm;
            end else begin
              fs_addr <= head.fs;
              ft_addr <= head.ft;
              fd_addr <= head.fd;
              start   <= 1'b1;
              stall   <= 1'b0;
              state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          start <= 1'b0;
          stall <= 1'b1;
          tcnt  <= '0;
          state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          // The last allowed sample is at tcnt == TIMEOUT-1, so err appears TIMEOUT cycles after entry.
          if (bus.working) begin
            state <= S_WAIT_LO;
          end else if (tcnt == TMO_W'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + TMO_W'(1);
          end
        end
        S_WAIT_LO: begin
          if (!bus.working) begin
            done_cnt <= done_cnt + 8'd1;
            state    <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = ~full;
  assign bus.idle     = empty & (state == S_IDLE) & ~m_write;
  assign bus.start    = start;
  assign bus.stall    = stall;
  assign bus.fs_addr  = fs_addr;
  assign bus.ft_addr  = ft_addr;
  assign bus.fd_addr  = fd_addr;
  assign bus.m_addr   = m_addr;
  assign bus.m_data   = m_data;
  assign bus.m_write  = m_write;
  assign bus.err      = err;
  assign bus.done_cnt = done_cnt;
endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed bench for fp_issue_ctrl: a table of single instructions with hand-computed
// results, then hand-written sequences for ordering, back-pressure, timeout, wrap and reset.
module tb_fp_issue_ctrl;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_issue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fp_issue_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        op;
    logic [3:0]  fs;
    logic [3:0]  ft;
    logic [3:0]  fd;
    logic [15:0] imm;
    logic [3:0]  exp_a0;
    logic [3:0]  exp_a1;
    logic [3:0]  exp_a2;
    logic [15:0] exp_data;
    logic [7:0]  exp_done;
  } vec_t;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          hi_len = 3;
  bit          hold_hi = 1'b0;
  int          rem = 0;
  logic [11:0] start_log [$];
  logic [7:0]  exp_done = 8'd0;

  // FPU model: working rises the cycle after start and stays high for hi_len cycles.
  initial begin
    bus.working = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rem > 0) begin
        bus.working = 1'b1;
        rem--;
      end else begin
        bus.working = hold_hi;
      end
      if (bus.start === 1'b1) rem = hi_len;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.start === 1'b1) start_log.push_back({bus.fs_addr, bus.ft_addr, bus.fd_addr});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timed_out(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: DUT event did not occur within the cycle budget", name);
  endtask

  task automatic set_in(input logic op, input logic [3:0] fs, input logic [3:0] ft,
                        input logic [3:0] fd, input logic [15:0] imm);
    bus.in_op  = op;
    bus.in_fs  = fs;
    bus.in_ft  = ft;
    bus.in_fd  = fd;
    bus.in_imm = imm;
  endtask

  // Called just after a falling edge; returns one falling edge after the transfer.
  task automatic push(input logic op, input logic [3:0] fs, input logic [3:0] ft,
                      input logic [3:0] fd, input logic [15:0] imm);
    int g;
    set_in(op, fs, ft, fd, imm);
    bus.in_valid = 1'b1;
    g = 0;
    while (bus.in_ready !== 1'b1 && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) timed_out("push_accept");
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int g;
    g = 0;
    while (bus.start !== 1'b1 && g < 30) begin
      @(negedge clk);
      g++;
    end
    if (g >= 30) timed_out(name);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int g;
    g = 0;
    while (bus.idle !== 1'b1 && g < budget) begin
      @(negedge clk);
      g++;
    end
    if (g >= budget) timed_out(name);
  endtask

  initial begin
    vec_t tbl [6];
    int   g;
    int   cyc;
    int   bad;
    int   viol;
    bit   seen;
    logic [3:0]  got_addr;
    logic [15:0] got_data;
    logic [7:0]  got_done;
    int   n_wrap;

    tbl[0] = '{1'b1, 4'd0,  4'd0,  4'd0,  16'h0000, 4'd0,  4'd0,  4'd0,  16'h0000, 8'd0};
    tbl[1] = '{1'b1, 4'd0,  4'd0,  4'd15, 16'hFFFF, 4'd0,  4'd0,  4'd15, 16'hFFFF, 8'd0};
    tbl[2] = '{1'b0, 4'd0,  4'd15, 4'd1,  16'h1111, 4'd0,  4'd15, 4'd1,  16'h0000, 8'd1};
    tbl[3] = '{1'b0, 4'd15, 4'd15, 4'd15, 16'h2222, 4'd15, 4'd15, 4'd15, 16'h0000, 8'd2};
    tbl[4] = '{1'b1, 4'd3,  4'd5,  4'd7,  16'h8001, 4'd0,  4'd0,  4'd7,  16'h8001, 8'd2};
    tbl[5] = '{1'b0, 4'd7,  4'd0,  4'd9,  16'h3333, 4'd7,  4'd0,  4'd9,  16'h0000, 8'd3};

    bus.in_valid = 1'b0;
    set_in(1'b0, 4'd0, 4'd0, 4'd0, 16'h0000);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_start",    32'(bus.start),    32'd0);
    check("rst_stall",    32'(bus.stall),    32'd1);
    check("rst_m_write",  32'(bus.m_write),  32'd0);
    check("rst_err",      32'(bus.err),      32'd0);
    check("rst_done_cnt", 32'(bus.done_cnt), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_idle",     32'(bus.idle),     32'd1);
    check("rst_addrs",    32'({bus.fs_addr, bus.ft_addr, bus.fd_addr, bus.m_addr}), 32'd0);
    check("rst_m_data",   32'(bus.m_data),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    hi_len = 3;
    for (int i = 0; i < 6; i++) begin
      push(tbl[i].op, tbl[i].fs, tbl[i].ft, tbl[i].fd, tbl[i].imm);
      g = 0;
      if (tbl[i].op) begin
        while (bus.m_write !== 1'b1 && g < 20) begin
          @(negedge clk);
          g++;
        end
        if (g >= 20) timed_out($sformatf("tbl%0d_m_write", i));
        else begin
          check($sformatf("tbl%0d_m_addr", i), 32'(bus.m_addr), 32'(tbl[i].exp_a2));
          check($sformatf("tbl%0d_m_data", i), 32'(bus.m_data), 32'(tbl[i].exp_data));
        end
      end else begin
        wait_start($sformatf("tbl%0d_start", i));
        check($sformatf("tbl%0d_issue_addrs", i),
              32'({bus.fs_addr, bus.ft_addr, bus.fd_addr}),
              32'({tbl[i].exp_a0, tbl[i].exp_a1, tbl[i].exp_a2}));
      end
      wait_idle($sformatf("tbl%0d_idle", i), 40);
      check($sformatf("tbl%0d_done_cnt", i), 32'(bus.done_cnt), 32'(tbl[i].exp_done));
      check($sformatf("tbl%0d_err", i), 32'(bus.err), 32'd0);
    end
    exp_done = 8'd3;

    // Back-to-back FLOADs write on consecutive cycles.
    push(1'b1, 4'd0, 4'd0, 4'd2, 16'h3C00);
    push(1'b1, 4'd0, 4'd0, 4'd3, 16'h4000);
    check("fl1_m_write", 32'(bus.m_write), 32'd1);
    check("fl1_m_addr_data", 32'({bus.m_addr, bus.m_data}), 32'({4'd2, 16'h3C00}));
    @(negedge clk);
    check("fl2_m_write", 32'(bus.m_write), 32'd1);
    check("fl2_m_addr_data", 32'({bus.m_addr, bus.m_data}), 32'({4'd3, 16'h4000}));
    @(negedge clk);
    check("fl_after_m_write", 32'(bus.m_write), 32'd0);
    check("fl_after_idle", 32'(bus.idle), 32'd1);

    // FADD with working high for 5 cycles.
    hi_len = 5;
    start_log.delete();
    push(1'b0, 4'd2, 4'd3, 4'd4, 16'h0000);
    wait_start("fadd_start");
    check("fadd_stall_at_start", 32'(bus.stall), 32'd0);
    check("fadd_addrs_at_start", 32'({bus.fs_addr, bus.ft_addr, bus.fd_addr}), 32'h234);
    cyc = 0;
    bad = 0;
    while (bus.done_cnt === exp_done && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (bus.done_cnt === exp_done) begin
        if (bus.start !== 1'b0 || bus.stall !== 1'b1 ||
            {bus.fs_addr, bus.ft_addr, bus.fd_addr} !== 12'h234) bad++;
      end
    end
    exp_done = exp_done + 8'd1;
    check("fadd_done_cnt", 32'(bus.done_cnt), 32'(exp_done));
    check("fadd_start_to_done_cycles", 32'(cyc), 32'd7);
    check("fadd_hold_violations", 32'(bad), 32'd0);
    check("fadd_idle_after", 32'(bus.idle), 32'd1);
    check("fadd_start_pulses", 32'(start_log.size()), 32'd1);

    // FLOAD behind an FADD waits for the FADD to finish.
    push(1'b0, 4'd5, 4'd6, 4'd7, 16'h0000);
    push(1'b1, 4'd0, 4'd0, 4'd4, 16'h1234);
    viol = 0;
    seen = 1'b0;
    got_addr = '0;
    got_data = '0;
    got_done = '0;
    cyc = 0;
    while (!(seen && bus.idle === 1'b1) && cyc < 40) begin
      if (bus.m_write === 1'b1 && bus.working === 1'b1) viol++;
      if (bus.m_write === 1'b1 && !seen) begin
        seen = 1'b1;
        got_addr = bus.m_addr;
        got_data = bus.m_data;
        got_done = bus.done_cnt;
      end
      @(negedge clk);
      cyc++;
    end
    exp_done = exp_done + 8'd1;
    check("order_m_write_seen", 32'(seen), 32'd1);
    check("order_write_while_working", 32'(viol), 32'd0);
    check("order_m_addr_data", 32'({got_addr, got_data}), 32'({4'd4, 16'h1234}));
    check("order_done_before_write", 32'(got_done), 32'(exp_done));

    // Back-pressure: the unit is stuck busy while the queue fills.
    hi_len = 2;
    hold_hi = 1'b1;
    push(1'b0, 4'd1, 4'd1, 4'd1, 16'h0000);
    repeat (4) @(negedge clk);
    check("bp_busy_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_busy_idle", 32'(bus.idle), 32'd0);
    start_log.delete();
    for (int k = 2; k < 6; k++) push(1'b0, 4'(k), 4'd0, 4'(k), 16'h0000);
    check("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    set_in(1'b0, 4'd6, 4'd0, 4'd6, 16'h0000);
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("bp_held_in_ready", 32'(bus.in_ready), 32'd0);
    hold_hi = 1'b0;
    g = 0;
    while (bus.in_ready !== 1'b1 && g < 10) begin
      @(negedge clk);
      g++;
    end
    if (g >= 10) timed_out("bp_in_ready_rise");
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_idle("bp_drain", 200);
    exp_done = exp_done + 8'd6;
    check("bp_issue_count", 32'(start_log.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < start_log.size())
        check($sformatf("bp_issue%0d_fd", k), 32'(start_log[k][3:0]), 32'(k + 2));
    end
    check("bp_done_cnt", 32'(bus.done_cnt), 32'(exp_done));

    // done_cnt wraps from 255 to 0.
    hi_len = 1;
    n_wrap = 256 - int'(exp_done);
    for (int k = 0; k < n_wrap; k++) push(1'b0, 4'd1, 4'd2, 4'(k), 16'h0000);
    wait_idle("wrap_drain", 300);
    exp_done = 8'd0;
    check("wrap_done_cnt", 32'(bus.done_cnt), 32'(exp_done));
    check("wrap_err", 32'(bus.err), 32'd0);

    // Timeout: working never rises; the queued FLOAD issues afterwards.
    hi_len = 0;
    push(1'b0, 4'd8, 4'd9, 4'd10, 16'h0000);
    push(1'b1, 4'd0, 4'd0, 4'd11, 16'hBEEF);
    wait_start("tmo_start");
    repeat (3) @(negedge clk);
    check("tmo_err_early", 32'(bus.err), 32'd0);
    @(negedge clk);
    check("tmo_err_set", 32'(bus.err), 32'd1);
    check("tmo_done_unchanged", 32'(bus.done_cnt), 32'(exp_done));
    @(negedge clk);
    check("tmo_next_m_write", 32'(bus.m_write), 32'd1);
    check("tmo_next_m_addr_data", 32'({bus.m_addr, bus.m_data}), 32'({4'd11, 16'hBEEF}));
    wait_idle("tmo_idle", 20);
    check("tmo_err_sticky", 32'(bus.err), 32'd1);

    // Asynchronous reset in WAIT_LO with three entries queued.
    hi_len = 3;
    hold_hi = 1'b1;
    push(1'b0, 4'd1, 4'd2, 4'd3, 16'h0000);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) push(1'b0, 4'd4, 4'd5, 4'(k), 16'h0000);
    check("pre_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("pre_rst_idle", 32'(bus.idle), 32'd0);
    rst = 1'b1;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_stall", 32'(bus.stall), 32'd1);
    check("arst_start", 32'(bus.start), 32'd0);
    check("arst_idle", 32'(bus.idle), 32'd1);
    check("arst_err", 32'(bus.err), 32'd0);
    check("arst_fd_addr", 32'(bus.fd_addr), 32'd0);
    hold_hi = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    start_log.delete();
    repeat (6) @(negedge clk);
    check("post_rst_done_cnt", 32'(bus.done_cnt), 32'd0);
    check("post_rst_idle", 32'(bus.idle), 32'd1);
    check("post_rst_no_issue", 32'(start_log.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
